// File: rtl/qbert_switch_pkg.sv
// Shared definitions for the Qbert slide-switch controller.
//   - Avalon word addresses of the four controller registers.
//   - Debounce settings used by the full system build (50 MHz clock).
package qbert_switch_pkg;

  localparam logic [1:0] SW_ADDR_DATA    = 2'd0;
  localparam logic [1:0] SW_ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] SW_ADDR_RAW     = 2'd2;
  localparam logic [1:0] SW_ADDR_EDGECAP = 2'd3;

  // 1 ms of stable input at 50 MHz before a switch level is accepted.
  localparam int SW_DEBOUNCE_CYCLES_SYS = 50000;
  localparam int SW_CNT_W_SYS           = 16;

endpackage : qbert_switch_pkg

// File: rtl/qbert_switch_debounce.sv
// Single-bit switch conditioner: 2-FF synchronizer, debounce counter and
// debounced level register.
//   clk, reset_n : system clock, asynchronous active-low reset
//   pin_i        : raw asynchronous switch pin
//   sync_o       : synchronized (second stage) sample
//   level_o      : debounced level
//   rise_o       : high during the cycle whose clock edge moves level 0->1
module qbert_switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic sync_o,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; any
  // sample that agrees restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchronizer stages
      // distinct flops regardless of statement order.
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o  = sync_q;
  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;

endmodule : qbert_switch_debounce

// File: rtl/qbert_only_switch_ctrl.sv
// Avalon-MM slave for the board slide switches read by the Qbert CPU.
// Each switch is synchronized and debounced; rising edges of the debounced
// level are captured and can raise a level-sensitive interrupt.
//   clk, reset_n        : system clock, asynchronous active-low reset
//   address[1:0]        : word address (DATA, IRQMASK, RAW, EDGECAP)
//   chipselect, write_n : write when chipselect=1 and write_n=0
//   writedata[31:0]     : write data (IRQMASK value / EDGECAP clear mask)
//   readdata[31:0]      : registered read data, latency 1
//   in_port[WIDTH-1:0]  : raw asynchronous switch pins
//   irq                 : |(edgecapture & irqmask), registered
module qbert_only_switch_ctrl
  import qbert_switch_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w, level_w, rise_w;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    qbert_switch_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (in_port[i]),
      .sync_o  (sync_w[i]),
      .level_o (level_w[i]),
      .rise_o  (rise_w[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  // Bits above WIDTH are never stored.
  assign unused_wdata = ^writedata;

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && address == SW_ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end

    // A rising edge in the same cycle as its clear keeps the bit set.
    edgecap_d = edgecap_q;
    if (wr_en && address == SW_ADDR_EDGECAP) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | rise_w;

    irq_d = |(edgecap_q & irqmask_q);

    readdata_d = '0;
    unique case (address)
      SW_ADDR_DATA:    readdata_d[WIDTH-1:0] = level_w;
      SW_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      SW_ADDR_RAW:     readdata_d[WIDTH-1:0] = sync_w;
      SW_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:         readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule : qbert_only_switch_ctrl

// File: tb/tb_qbert_only_switch_ctrl.sv
// Self-checking bench for qbert_only_switch_ctrl: directed scenarios with
// literal expectations plus randomized traffic, all checked every cycle
// against a window-based behavioural model.
module tb_qbert_only_switch_ctrl;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port = '0;
  logic             irq;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  qbert_only_switch_ctrl #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the level of a bit flips once the last DEB
  // synchronized samples all disagree with it. Synchronized samples are the
  // pin values from two edges earlier (zero straight after reset).
  logic [WIDTH-1:0] m_s1, m_s2, m_lvl, m_ec, m_mask;
  logic [WIDTH-1:0] m_hist [DEB-1];
  logic             m_irq;
  logic [31:0]      m_rd;

  always @(posedge clk or negedge reset_n) begin
    logic [WIDTH-1:0] seen, flip, nl, clr;
    if (!reset_n) begin
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_ec <= '0; m_mask <= '0;
      m_irq <= 1'b0; m_rd <= '0;
      for (int k = 0; k < DEB - 1; k++) m_hist[k] <= '0;
    end else begin
      seen = m_s2;
      for (int i = 0; i < WIDTH; i++) begin
        flip[i] = (seen[i] != m_lvl[i]);
        for (int k = 0; k < DEB - 1; k++) flip[i] = flip[i] & (m_hist[k][i] != m_lvl[i]);
      end
      nl  = m_lvl ^ flip;
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
      m_ec <= (m_ec & ~clr) | (nl & ~m_lvl);
      if (chipselect && !write_n && address == 2'd1) m_mask <= writedata[WIDTH-1:0];
      m_irq <= |(m_ec & m_mask);
      case (address)
        2'd0:    m_rd <= 32'(m_lvl);
        2'd1:    m_rd <= 32'(m_mask);
        2'd2:    m_rd <= 32'(m_s2);
        default: m_rd <= 32'(m_ec);
      endcase
      m_lvl <= nl;
      for (int k = DEB - 2; k > 0; k--) m_hist[k] <= m_hist[k-1];
      m_hist[0] <= seen;
      m_s2 <= m_s1;
      m_s1 <= in_port;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    write_n = 1'b1; chipselect = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    check("reset_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) read_chk(2'(a), 32'd0, "reset_read");

    // Held change: level rises on the 10th edge, readdata shows it one later.
    @(negedge clk);
    in_port = 4'b0001; address = 2'd0; chipselect = 1'b1;
    repeat (10) @(negedge clk);
    check("data_edge10", readdata, 32'h0);
    @(negedge clk);
    check("data_edge11", readdata, 32'h1);
    read_chk(2'd3, 32'h1, "edgecap_rise0");

    // Short glitch on bit 2 never reaches the level.
    @(negedge clk);
    in_port = 4'b0101;
    repeat (5) @(negedge clk);
    in_port = 4'b0001;
    repeat (12) @(negedge clk);
    read_chk(2'd0, 32'h1, "glitch_data");
    read_chk(2'd3, 32'h1, "glitch_edgecap");

    // Mask then clear: irq follows one cycle after each register update.
    wr(2'd1, 32'h1);
    check("irq_mask_lat", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h1);
    check("irq_clr_lat", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_clr", {31'd0, irq}, 32'd0);
    read_chk(2'd3, 32'h0, "edgecap_w1c");

    // Clear of bit 1 on the very edge its level rises: set wins.
    @(negedge clk);
    in_port = 4'b0011;
    repeat (9) @(negedge clk);
    address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h2;
    @(negedge clk);
    write_n = 1'b1; chipselect = 1'b0;
    read_chk(2'd3, 32'h2, "w1c_vs_rise");
    wr(2'd3, 32'h0);
    read_chk(2'd3, 32'h2, "w1c_zero_keeps");
    read_chk(2'd0, 32'h3, "data_two_bits");
    read_chk(2'd2, 32'h3, "raw_two_bits");
    check("irq_masked_off", {31'd0, irq}, 32'd0);

    // Switches high through reset are captured after the debounce time.
    @(negedge clk);
    reset_n = 1'b0; in_port = 4'hF; address = 2'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    read_chk(2'd0, 32'hF, "reset_high_data");
    read_chk(2'd3, 32'hF, "reset_high_edgecap");
    wr(2'd1, 32'hF);
    repeat (2) @(negedge clk);
    check("irq_all", {31'd0, irq}, 32'd1);

    // Reset mid-count clears everything at once.
    address = 2'd0; chipselect = 1'b1;
    in_port = 4'h0;
    repeat (4) @(negedge clk);
    check("pre_reset_data", readdata, 32'hF);
    #2 reset_n = 1'b0;
    #1;
    check("async_rd", readdata, 32'h0);
    check("async_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    read_chk(2'd1, 32'h0, "post_reset_mask");
    read_chk(2'd3, 32'h0, "post_reset_edgecap");
    repeat (12) @(negedge clk);
    read_chk(2'd0, 32'h0, "post_reset_data");

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) in_port = WIDTH'($urandom);
      address    = 2'($urandom);
      chipselect = ($urandom_range(3) == 0);
      write_n    = ($urandom_range(1) == 0);
      writedata  = $urandom;
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_qbert_only_switch_ctrl
